// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Function : Synchronizes and debounces a switch level into a registered mode
//            with edge pulses, and paces the sequencer with a step enable.
// Revision : 1.0
// ============================================================================
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    input  logic tick_en,
    output logic mode_out,
    output logic mode_rise,
    output logic mode_fall,
    output logic step_tick,
    output logic bouncing
);
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_TK_W = $clog2(TICK_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TK_W-1:0] c_TK_LAST = c_TK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_W-1:0]      r_db_cnt;
    logic [c_TK_W-1:0]      r_tk_cnt;
    logic                   r_mode;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_tick;
    logic                   r_bouncing;

    logic w_sync;
    logic w_db_done;
    logic w_mode_edge;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_db_done = (r_db_cnt == c_DB_LAST);
    // Asserted on the edge that commits a new debounced level.
    assign w_mode_edge = ((r_state == WAIT_HI) &&  w_sync && w_db_done) ||
                         ((r_state == WAIT_LO) && !w_sync && w_db_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= STABLE_LO;
            r_db_cnt   <= '0;
            r_mode     <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_bouncing <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_sync) begin
                        r_state    <= WAIT_HI;
                        r_db_cnt   <= '0;
                        r_bouncing <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (!w_sync) begin
                        r_state    <= STABLE_LO;
                        r_db_cnt   <= '0;
                        r_bouncing <= 1'b0;
                    end else if (w_db_done) begin
                        r_state    <= STABLE_HI;
                        r_db_cnt   <= '0;
                        r_mode     <= 1'b1;
                        r_rise     <= 1'b1;
                        r_bouncing <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!w_sync) begin
                        r_state    <= WAIT_LO;
                        r_db_cnt   <= '0;
                        r_bouncing <= 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (w_sync) begin
                        r_state    <= STABLE_HI;
                        r_db_cnt   <= '0;
                        r_bouncing <= 1'b0;
                    end else if (w_db_done) begin
                        r_state    <= STABLE_LO;
                        r_db_cnt   <= '0;
                        r_mode     <= 1'b0;
                        r_fall     <= 1'b1;
                        r_bouncing <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= STABLE_LO;
                    r_db_cnt   <= '0;
                    r_bouncing <= 1'b0;
                end
            endcase
        end
    end

    // A mode change restarts the step phase so the sequencer steps a full
    // period after the user's action.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tk_cnt <= '0;
            r_tick   <= 1'b0;
        end else if (w_mode_edge) begin
            r_tk_cnt <= '0;
            r_tick   <= 1'b0;
        end else if (!tick_en) begin
            r_tick <= 1'b0;
        end else if (r_tk_cnt == c_TK_LAST) begin
            r_tk_cnt <= '0;
            r_tick   <= 1'b1;
        end else begin
            r_tk_cnt <= r_tk_cnt + 1'b1;
            r_tick   <= 1'b0;
        end
    end

    assign mode_out  = r_mode;
    assign mode_rise = r_rise;
    assign mode_fall = r_fall;
    assign step_tick = r_tick;
    assign bouncing  = r_bouncing;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Function : Scoreboard bench for input_conditioner (SYNC=2, DEBOUNCE=4, TICK=8).
// Revision : 1.0
// ============================================================================
module tb_input_conditioner;
    localparam int c_SYNC = 2;
    localparam int c_DB   = 4;
    localparam int c_TK   = 8;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic raw_in  = 1'b0;
    logic tick_en = 1'b0;
    logic mode_out, mode_rise, mode_fall, step_tick, bouncing;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Expected {mode_out, mode_rise, mode_fall, step_tick, bouncing} per edge
    logic [4:0] exp_q[$];

    logic [c_SYNC-1:0] m_sh   = '0;
    logic              m_mode = 1'b0;
    int                m_run  = 0;
    int                m_tk   = 0;

    input_conditioner #(
        .SYNC_STAGES    (c_SYNC),
        .DEBOUNCE_CYCLES(c_DB),
        .TICK_CYCLES    (c_TK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (raw_in),
        .tick_en  (tick_en),
        .mode_out (mode_out),
        .mode_rise(mode_rise),
        .mode_fall(mode_fall),
        .step_tick(step_tick),
        .bouncing (bouncing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {mode_out, mode_rise, mode_fall, step_tick, bouncing};
    endfunction

    // Model: mode flips once sync has disagreed with it for DEBOUNCE+1 edges in a row.
    task automatic step(input logic raw, input logic en);
        logic rise, fall, tick;
        raw_in  = raw;
        tick_en = en;
        rise = 1'b0;
        fall = 1'b0;
        tick = 1'b0;
        if (m_sh[c_SYNC-1] != m_mode) m_run++;
        else m_run = 0;
        if (m_run == c_DB + 1) begin
            m_mode = ~m_mode;
            rise   = m_mode;
            fall   = ~m_mode;
            m_run  = 0;
        end
        if (rise | fall) m_tk = 0;
        else if (en) begin
            if (m_tk == c_TK - 1) begin
                m_tk = 0;
                tick = 1'b1;
            end else m_tk++;
        end
        m_sh = {m_sh[c_SYNC-2:0], raw};
        exp_q.push_back({m_mode, rise, fall, tick, (m_run > 0)});
        @(posedge clk);
        #1;
        cyc++;
        check($sformatf("cyc%0d", cyc), outs(), exp_q.pop_front());
    endtask

    task automatic do_reset();
        #3 reset = 1'b0;
        #1;
        check("reset_outs", outs(), 5'b0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        m_sh   = '0;
        m_mode = 1'b0;
        m_run  = 0;
        m_tk   = 0;
        cyc    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Free-running ticks
        do_reset();
        for (int i = 1; i <= 24; i++) begin
            step(1'b0, 1'b1);
            if (i % 8 == 0) check($sformatf("tick_at_%0d", i), step_tick, 1);
        end

        // Clean press, then release
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(i >= 10, 1'b0);
            if (i == 12) check("press_busy_12", bouncing, 1);
            if (i == 15) check("press_mode_15", mode_out, 0);
            if (i == 16) check("press_rise_16", {mode_out, mode_rise}, 2'b11);
            if (i == 17) check("press_rise_17", mode_rise, 0);
        end
        for (int i = 1; i <= 10; i++) step(1'b0, 1'b0);
        check("release_mode", mode_out, 0);

        // Bounce reject
        do_reset();
        repeat (3) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        check("bounce_mode", mode_out, 0);
        check("bounce_busy", bouncing, 0);

        // Glitch restart: final rising sample at i=1, rise 6 edges later
        do_reset();
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            if (i == 6) check("glitch_early", mode_rise, 0);
            if (i == 7) check("glitch_rise", mode_rise, 1);
        end

        // Pause keeps the phase
        do_reset();
        repeat (5) step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("pause_tick%0d", i), step_tick, (i == 3));
        end

        // Fall at terminal count suppresses the tick and restarts the phase
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            step(i < 17, 1'b1);
            if (i == 7)  check("term_rise", mode_rise, 1);
            if (i == 15) check("term_tick15", step_tick, 1);
            if (i == 23) check("term_fall_sup", {mode_fall, step_tick}, 2'b10);
            if (i == 31) check("term_tick31", step_tick, 1);
        end

        // Reset during WAIT_HI with raw_in held high
        do_reset();
        repeat (4) step(1'b1, 1'b0);
        check("wait_busy", bouncing, 1);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0);
            if (i == 7) check("rst_rise", mode_rise, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage for the seven-segment state-sequencer. It turns the raw slide-switch/button level into a synchronized, debounced mode level with one-cycle edge pulses. It also generates the one-cycle step enable that paces the sequencer, replacing a toggled divided clock. All outputs are in the `clk` domain, so the downstream FSM runs on `clk` qualified by `step_tick`.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flip-flops on `raw_in`; minimum 2.
- `DEBOUNCE_CYCLES`, default 1000000: cycles the synchronized input must hold a new value before it is accepted. This is 20 ms at 50 MHz. Minimum 2.
- `TICK_CYCLES`, default 50000000: step period in `clk` cycles (1 s at 50 MHz); minimum 2.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-low.
- `raw_in` input, 1 bit: asynchronous mechanical switch level.
- `tick_en` input, 1 bit: synchronous; 1 means the step counter runs, 0 means it freezes.
- `mode_out` output, 1 bit: debounced switch level (registered).
- `mode_rise` output, 1 bit: one-cycle pulse when `mode_out` goes 0→1.
- `mode_fall` output, 1 bit: one-cycle pulse when `mode_out` goes 1→0.
- `step_tick` output, 1 bit: one-cycle step enable for the sequencer.
- `bouncing` output, 1 bit: high while the debouncer is in a WAIT state.

## Operation
- Reset (asynchronous assert, `reset`=0):
  - Synchronizer chain, `mode_out`, `mode_rise`, `mode_fall`, `step_tick`, `bouncing` and both counters are all cleared to 0.
  - The debounce FSM goes to STABLE_LO.
- Synchronizer: a `raw_in` shift chain of `SYNC_STAGES` registers; `sync` is the last stage. No other logic reads `raw_in`.
- Debounce FSM has four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: if `sync`=1, go to WAIT_HI with `db_cnt`=0.
  - WAIT_HI: if `sync`=0, return to STABLE_LO with `db_cnt`=0 (glitch rejected). Else if `db_cnt`=`DEBOUNCE_CYCLES`-1, go to STABLE_HI; `mode_out`←1 and `mode_rise`←1. Else `db_cnt`+1.
  - STABLE_HI and WAIT_LO are symmetric, using `sync`=0, `mode_out`←0 and `mode_fall`←1.
  - `bouncing`=1 exactly in WAIT_HI/WAIT_LO (registered with the state).
- Edge pulses are high for exactly one cycle, the same cycle `mode_out` first shows the new value. `mode_rise` and `mode_fall` are never high together.
- Step counter `tk_cnt` has width ceil(log2(`TICK_CYCLES`)). Priority per cycle:
  1. Debounced edge (`mode_rise`|`mode_fall` being set this edge): `tk_cnt`←0 and `step_tick`←0. This applies even at terminal count and even if `tick_en`=0.
  2. `tick_en`=0: `tk_cnt` holds and `step_tick`←0.
  3. `tk_cnt`=`TICK_CYCLES`-1: `tk_cnt`←0 and `step_tick`←1.
  4. Otherwise: `tk_cnt`+1 and `step_tick`←0.
- The debounce counter has width ceil(log2(`DEBOUNCE_CYCLES`)). It never wraps, because it is cleared on every WAIT exit.
- If `raw_in`=1 at reset release, the block treats it as a normal 0→1 change. `mode_rise` must pulse after the full latency.

## Timing
- Debounce latency: `raw_in` changes and is held, with edge E the first edge that samples the new value. `mode_out`, the pulse and the tick-counter restart then appear after edge E+`SYNC_STAGES`+`DEBOUNCE_CYCLES`.
- Any reversion of `sync` during WAIT restarts the full `DEBOUNCE_CYCLES` window.
- Tick period: with `tick_en`=1 and no mode edges, `step_tick` pulses every `TICK_CYCLES` cycles.
  - The first pulse comes `TICK_CYCLES` edges after reset release or after a mode edge.
- Clearing `tick_en` pauses the phase without losing it. After re-enabling, the next tick arrives after the remaining count.
- Reset mid-operation: all state clears immediately, with no pulse emitted on release.

## Test plan
All scenarios use `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `TICK_CYCLES`=8.
- Clean press: `raw_in` 0→1 sampled at edge 10 and held → `mode_out`=1 and `mode_rise`=1 for one cycle after edge 16; `bouncing`=1 after edges 12–15.
- Bounce reject: `raw_in`=1 for 3 cycles, then 0 → `mode_out` stays 0, no pulses, and `bouncing` returns to 0.
- Glitch restart: `raw_in` 1 for 3 cycles, 0 for 1 cycle, then 1 held → `mode_rise` comes 6 edges after the final rising sample.
- Free-running ticks: `tick_en`=1, `raw_in`=0 from reset → `step_tick` is high after edges 8, 16, 24, each one cycle wide.
- Pause and edge restart:
  - Drop `tick_en` after edge 5 for 10 cycles → next tick comes 3 enabled cycles later.
  - A `mode_fall` at terminal count suppresses that tick, and the next tick follows 8 edges later.
- Reset mid-wait: assert `reset` during WAIT_HI → all outputs 0 at once; with `raw_in`=1 held, `mode_rise` comes 6 edges after release.
